// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter receive path and its transmitter bench.
// Functions work on 32-bit words; narrower counts are zero-extended, which leaves the conversion intact.
package gray_pkg;

    localparam int CBITS_DEF = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_decode.sv
// Purpose: CBITS-wide Gray-to-binary converter.
// Latency: purely combinational. Backpressure: none, no state.
module gray_decode
    import gray_pkg::*;
#(
    parameter int CBITS = CBITS_DEF
) (
    input  logic [CBITS-1:0] gray,
    output logic [CBITS-1:0] bin
);

    // Each binary bit is the XOR of its own Gray bit and every more-significant one.
    always_comb begin
        bin = '0;
        for (int i = 0; i < CBITS; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_rx.sv
// Purpose: decode Gray count words, check successor sequence, track lock, flag wrap/errors.
// Latency: 1 cycle input to all outputs. Backpressure: none, accepts one word per cycle.
// Optional error counter built only when GRAY_RX_ERRCNT_EN is defined; otherwise err_cnt is tied to 0.
module gray_rx
    import gray_pkg::*;
#(
    parameter int CBITS     = CBITS_DEF,
    parameter int LOCK_N    = 4,
    parameter int ECNT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [CBITS-1:0]     gray_in,
    output logic [CBITS-1:0]     bin_out,
    output logic                 bin_vld,
    output logic                 locked,
    output logic                 sig,
    output logic                 err,
    output logic [ECNT_BITS-1:0] err_cnt
);

    state_t           state;
    logic [CBITS-1:0] prev;
    logic [3:0]       good_cnt;
    logic [CBITS-1:0] dec;
    logic [CBITS-1:0] succ;
    logic [3:0]       cnt_inc;
    logic             good;

    gray_decode #(.CBITS(CBITS)) u_dec (
        .gray (gray_in),
        .bin  (dec)
    );

    // Successor compare is modular at CBITS so the all-ones to zero step counts as good.
    assign succ    = CBITS'(prev + 1'b1);
    assign good    = (dec == succ);
    assign cnt_inc = good_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= '0;
            good_cnt <= '0;
            bin_out  <= '0;
            bin_vld  <= 1'b0;
            locked   <= 1'b0;
            sig      <= 1'b0;
            err      <= 1'b0;
        end else begin
            bin_vld <= 1'b0;
            sig     <= 1'b0;
            err     <= 1'b0;
            if (in_vld) begin
                bin_out <= dec;
                bin_vld <= 1'b1;
                prev    <= dec;
                case (state)
                    IDLE: begin
                        good_cnt <= '0;
                        state    <= TRACK;
                    end
                    TRACK: begin
                        if (good) begin
                            good_cnt <= cnt_inc;
                            if (cnt_inc == 4'(LOCK_N)) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        if (good) begin
                            sig <= (dec == '0);
                        end else begin
                            err      <= 1'b1;
                            good_cnt <= '0;
                            state    <= TRACK;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GRAY_RX_ERRCNT_EN
    // Saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (in_vld && state == LOCK && !good && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/gray_rx.md
# gray_rx

Receive-side companion to the free-running Gray-code counter. Samples a Gray-coded count word and converts it back to binary with one cycle of latency. Checks that every accepted word is the exact successor of the previous one, and maintains a lock state. Flags the wrap-to-zero point and any broken sequence once locked.

## Interface
- `CBITS`, default 11: width of the Gray/binary count word.
- `LOCK_N`, default 4: number of consecutive good steps needed to enter lock; range 1..15.
- `ECNT_BITS`, default 8: width of the error counter.

- `clk`  in  1: sole clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_vld`  in  1: `gray_in` is valid this cycle.
- `gray_in`  in  CBITS: Gray-coded count word.
- `bin_out`  out  CBITS: decoded binary value (registered).
- `bin_vld`  out  1: `bin_out` is valid; one-cycle pulse per accepted word.
- `locked`  out  1: high while the state is LOCK.
- `sig`  out  1: one-cycle pulse when a locked, good step decodes to 0 (wrap).
- `err`  out  1: one-cycle pulse on a bad step while locked.
- `err_cnt`  out  ECNT_BITS: saturating count of `err` pulses.

## Operation
- **Decode:** b[CBITS-1] = g[CBITS-1]; b[i] = b[i+1] ^ g[i] for i from CBITS-2 down to 0.
- **Good step:** decoded value == (prev + 1) mod 2^CBITS. Any other value is a bad step, including a repeat of prev.
- **prev register:** loaded with the decoded value on every accepted word, whether good or bad.
- **FSM states:** IDLE, TRACK, LOCK. Reset state is IDLE; `good_cnt` resets to 0.
  - IDLE, `in_vld`: load prev, set `good_cnt` to 0, go to TRACK. No check is made on this first word.
  - TRACK, `in_vld`, good step: increment `good_cnt`. When it reaches LOCK_N, go to LOCK.
  - TRACK, `in_vld`, bad step: clear `good_cnt` and stay in TRACK. `err` is not asserted.
  - LOCK, `in_vld`, good step: stay in LOCK. If the decoded value is 0, assert `sig`.
  - LOCK, `in_vld`, bad step: assert `err`, clear `good_cnt`, go to TRACK.
- **`in_vld` low:** state, prev, `good_cnt` and `bin_out` all hold. `bin_vld`, `sig` and `err` are 0. There is no timeout.
- **Wrap:** the step from 2^CBITS-1 to 0 is a good step (modular compare at width CBITS).
- **Reset mid-operation:** reset wins over `in_vld` in the same cycle. All registers return to their reset values on the next edge. The word sampled in that cycle is discarded.

## Timing
- Reset values: `bin_out` 0, `bin_vld` 0, `locked` 0, `sig` 0, `err` 0, `err_cnt` 0.
- Latency: a word accepted in cycle t appears with `bin_vld` high in cycle t+1. `sig` and `err` for that word are also in cycle t+1.
- `locked` rises in the same cycle as the `bin_vld` of the LOCK_N-th good step.
- `locked` falls in the same cycle as the `err` pulse.
- Every output is a flop output; there is no combinational path from input to output.
- Back-to-back `in_vld` is supported at one word per cycle.

## Configuration
- `GRAY_RX_ERRCNT_EN` defined: `err_cnt` increments on each `err` pulse and saturates at 2^ECNT_BITS-1. It is cleared only by `rst`.
- `GRAY_RX_ERRCNT_EN` undefined: no counter logic is built. The `err_cnt` port still exists and is tied to 0. All other behaviour is identical.

## Structure
- Package `gray_pkg`:
  - FSM state enum typedef (IDLE/TRACK/LOCK).
  - Default-width constant CBITS_DEF = 11.
  - Shared `gray2bin`/`bin2gray` functions, for reuse by the transmitter bench.
- Sub-module `gray_decode`: purely combinational CBITS-wide Gray-to-binary converter, instanced once.
- FSM, check, `good_cnt` and output registers live in `gray_rx`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `in_vld` toggling -> all outputs 0 and state IDLE.
- **Lock from 0:** feed Gray 0,1,3,2,6 on consecutive cycles -> `bin_out` 0,1,2,3,4. `locked` rises with `bin_out` = 4. `err` and `sig` stay 0.
- **Wrap:** once locked, feed binary 2046, 2047, 0 (Gray 0x401, 0x400, 0x000) -> `sig` = 1 only with `bin_out` = 0; `locked` stays 1.
- **Break and relock:** while locked, feed binary 10 then 12 -> `err` pulses with `bin_out` = 12 and `locked` drops. Feed 13,14,15,16 -> `locked` rises with 16. `err_cnt` = 1 with the macro, 0 without.
- **Gaps and repeat:** in LOCK, drop `in_vld` for 5 cycles -> outputs hold, no pulses. Then repeat the last value -> `err` pulses.
- **Reset mid-lock and saturation:** with ECNT_BITS = 2, force 5 errors -> `err_cnt` reaches 3 and stays at 3. Assert `rst` while locked -> `err_cnt`, `locked` and `bin_out` are 0 on the next cycle.
